dac_wave_spi_gen: RTL and testbench

//   Parametrised DAC test-pattern source. Generates saw/triangle/square/constant samples

---
 rtl/dac_wave_spi_gen_if.sv | 24 ++
 rtl/dac_wave_spi_gen.sv | 149 ++++++++++++++
 tb/tb_dac_wave_spi_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dac_wave_spi_gen_if.sv
// Control and DAC-pin bundle for the test-pattern SPI source.
// master = system/bench side, slave = generator side.
interface dac_wave_spi_gen_if #(
    parameter int DATA_W = 8
);
    logic              en;
    logic [1:0]        mode;
    logic [DATA_W-1:0] level;
    logic              dac_sync;
    logic              dac_sclk;
    logic              dac_sdi;
    logic              busy;
    logic              frame_done;

    modport master (
        output en, mode, level,
        input  dac_sync, dac_sclk, dac_sdi, busy, frame_done
    );

    modport slave (
        input  en, mode, level,
        output dac_sync, dac_sclk, dac_sdi, busy, frame_done
    );
endinterface

// File: rtl/dac_wave_spi_gen.sv
// DAC test-pattern source: phase accumulator -> saw/triangle/square/constant sample,
// each sample shipped MSB first as one SPI frame (SYNC/SCLK/SDI).
module dac_wave_spi_gen #(
    parameter int DATA_W   = 8,
    parameter int FRAME_W  = 16,
    parameter int DATA_LSB = 4,
    parameter int CLK_DIV  = 1,
    parameter int STEP_DIV = 1000,
    parameter int GAP_CYC  = 1
) (
    input logic              clk,
    input logic              rst_n,
    dac_wave_spi_gen_if.slave bus
);
    localparam int M  = DATA_W - 1;
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int GW = (GAP_CYC  > 1) ? $clog2(GAP_CYC)  : 1;
    localparam int BW = (FRAME_W  > 1) ? $clog2(FRAME_W)  : 1;

    if (DATA_LSB + DATA_W > FRAME_W) begin : g_bad_cfg
        $error("sample field does not fit in the SPI frame");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t              state, state_d;
    logic [SW-1:0]       step;
    logic [DATA_W-1:0]   phase, sample;
    logic [FRAME_W-1:0]  shreg, shreg_d;
    logic [DW-1:0]       div_cnt, div_d;
    logic [BW-1:0]       bit_cnt, bit_d;
    logic [GW-1:0]       gap_cnt, gap_d;
    logic                sync_q, sclk_q, sdi_q, busy_q, done_q;
    logic                sync_d, sclk_d, sdi_d, busy_d, done_d;

    // Phase advances only while enabled, independent of the frame engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step  <= '0;
            phase <= '0;
        end else if (bus.en) begin
            if (step == SW'(STEP_DIV - 1)) begin
                step  <= '0;
                phase <= phase + 1'b1;
            end else begin
                step  <= step + 1'b1;
            end
        end
    end

    always_comb begin
        case (bus.mode)
            2'b00:   sample = phase;
            2'b01:   sample = phase[M] ? ~{phase[M-1:0], 1'b0} : {phase[M-1:0], 1'b0};
            2'b10:   sample = {DATA_W{phase[M]}};
            default: sample = bus.level;
        endcase
    end

    always_comb begin
        state_d = state;
        shreg_d = shreg;
        div_d   = div_cnt;
        bit_d   = bit_cnt;
        gap_d   = gap_cnt;
        sync_d  = sync_q;
        sclk_d  = sclk_q;
        sdi_d   = sdi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state)
            IDLE: if (bus.en) begin
                shreg_d = FRAME_W'(sample) << DATA_LSB;
                sync_d  = 1'b0;
                sdi_d   = shreg_d[FRAME_W-1];
                sclk_d  = 1'b0;
                busy_d  = 1'b1;
                bit_d   = '0;
                div_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (div_cnt == DW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt == BW'(FRAME_W - 1)) begin
                        sync_d  = 1'b1;
                        sclk_d  = 1'b0;
                        sdi_d   = 1'b0;
                        done_d  = 1'b1;
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        // SDI only moves on the falling SCLK edge
                        sclk_d  = 1'b0;
                        bit_d   = bit_cnt + 1'b1;
                        shreg_d = shreg << 1;
                        sdi_d   = shreg[FRAME_W-2];
                    end
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sync_q  <= 1'b1;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            div_cnt <= div_d;
            bit_cnt <= bit_d;
            gap_cnt <= gap_d;
            sync_q  <= sync_d;
            sclk_q  <= sclk_d;
            sdi_q   <= sdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dac_sync   = sync_q;
    assign bus.dac_sclk   = sclk_q;
    assign bus.dac_sdi    = sdi_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_dac_wave_spi_gen.sv
// Two generators (fast default timing, slow CLK_DIV=3/GAP_CYC=4) share stimulus; a cycle model
// queues each expected frame word and an SPI monitor captures and checks what reaches the pins.
module tb_dac_wave_spi_gen;
    localparam int SDIV = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic [1:0] mode  = 2'b11;
    logic [7:0] level = 8'hA5;
    int         n_tests = 0;
    int         n_fail  = 0;
    event       idle_ev, fin_ev;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_frame(input logic [1:0] md, input logic [7:0] lv,
                                              input logic [7:0] p);
        int v;
        case (md)
            2'd0:    v = int'(p);
            2'd1:    v = (p < 8'd128) ? 2 * int'(p) : 255 - 2 * (int'(p) - 128);
            2'd2:    v = (p >= 8'd128) ? 255 : 0;
            default: v = int'(lv);
        endcase
        return 16'(v << 4);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CD   = (g == 0) ? 1 : 3;
        localparam int GC   = (g == 0) ? 1 : 4;
        localparam int NLOW = 32 * CD;
        localparam int PER  = NLOW + GC + 1;

        dac_wave_spi_gen_if #(.DATA_W(8)) bus ();
        assign bus.en    = en;
        assign bus.mode  = mode;
        assign bus.level = level;

        dac_wave_spi_gen #(
            .DATA_W(8), .FRAME_W(16), .DATA_LSB(4),
            .CLK_DIV(CD), .STEP_DIV(SDIV), .GAP_CYC(GC)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        logic [15:0] q[$];
        int          m_left, m_step;
        logic [7:0]  m_ph;

        // Reference: frame launch timing and phase accumulator.
        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_left = 0;
                m_step = 0;
                m_ph   = 8'h00;
            end else begin
                if (m_left == 0) begin
                    if (en) begin
                        q.push_back(exp_frame(mode, level, m_ph));
                        m_left = PER - 1;
                    end
                end else begin
                    m_left--;
                end
                if (en) begin
                    if (m_step == SDIV - 1) begin
                        m_step = 0;
                        m_ph   = m_ph + 8'd1;
                    end else begin
                        m_step++;
                    end
                end
            end
        end

        int          cyc = 0, last_fall = -1, low_len, bits, rise_last, gap_len, vio, frames = 0;
        logic [15:0] cap;
        logic        s, k, d, b, fd, ps = 1'b1, pk = 1'b0, pd = 1'b0, pb = 1'b0;
        bit          en_cont = 1'b0, pr_rise = 1'b0;

        // Pin monitor, sampled mid-cycle.
        initial forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                ps = 1'b1; pk = 1'b0; pd = 1'b0; pb = 1'b0;
                last_fall = -1; low_len = 0; bits = 0; pr_rise = 1'b0; en_cont = 1'b0;
            end else begin
                s = bus.dac_sync; k = bus.dac_sclk; d = bus.dac_sdi;
                b = bus.busy;     fd = bus.frame_done;
                if (pr_rise) chk("frame_done_width", fd, 0);
                pr_rise = 1'b0;
                if (!s && ps) begin
                    chk("busy_at_frame_start", b, 1);
                    if (last_fall >= 0 && en_cont) chk("frame_period", cyc - last_fall, PER);
                    last_fall = cyc; en_cont = 1'b1;
                    low_len = 0; bits = 0; cap = '0; vio = 0;
                end
                if (!en) en_cont = 1'b0;
                if (!s) begin
                    low_len++;
                    if (k && !pk) begin
                        if (bits > 0) chk("sclk_period", cyc - rise_last, 2 * CD);
                        rise_last = cyc;
                        cap = {cap[14:0], d};
                        bits++;
                    end
                    if (k && pk && d != pd) vio++;
                end
                if (s && !ps) begin
                    chk("sync_low_len", low_len, NLOW);
                    chk("sclk_rises", bits, 16);
                    chk("sdi_stable_high", vio, 0);
                    chk("frame_done_pulse", fd, 1);
                    chk("sclk_idle", k, 0);
                    chk("sdi_idle", d, 0);
                    chk("sb_nonempty", q.size() != 0, 1);
                    if (q.size() != 0) chk("frame_data", cap, q.pop_front());
                    frames++;
                    pr_rise = 1'b1;
                    gap_len = 0;
                end
                if (s && b) gap_len++;
                if (!b && pb && s) chk("gap_len", gap_len, GC);
                ps = s; pk = k; pd = d; pb = b;
            end
        end

        initial forever begin
            @(negedge rst_n);
            #1;
            chk("rst_sync", bus.dac_sync, 1);
            chk("rst_sclk", bus.dac_sclk, 0);
            chk("rst_sdi", bus.dac_sdi, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_frame_done", bus.frame_done, 0);
        end

        initial forever begin
            @(idle_ev);
            chk("idle_sync", bus.dac_sync, 1);
            chk("idle_busy", bus.busy, 0);
            chk("sb_drained", q.size(), 0);
        end

        initial forever begin
            @(fin_ev);
            chk("frames_seen", frames > 20, 1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #3 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        // Constant level, then a mid-frame level change and en drop
        en = 1'b1;
        step(300);
        step(11);
        level = 8'h3C;
        step(250);
        step(17);
        en = 1'b0;
        step(300);
        -> idle_ev;
        // Saw (covers 0xFF -> 0x00 wrap), triangle, square
        mode = 2'b00; en = 1'b1;
        step(1200);
        mode = 2'b01;
        step(1100);
        mode = 2'b10;
        step(1100);
        // Random en/mode/level churn, including en rising during GAP
        for (int i = 0; i < 24; i++) begin
            en    = 1'($urandom_range(0, 1));
            mode  = 2'($urandom_range(0, 3));
            level = 8'($urandom_range(0, 255));
            step($urandom_range(5, 60));
        end
        // Reset mid-frame: first frame afterwards carries phase 0
        mode = 2'b00; en = 1'b1;
        step(40);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(300);
        en = 1'b0;
        step(300);
        -> idle_ev;
        #1;
        -> fin_ev;
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
